// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE accepts a request, EXEC drives
// the captured operands to the execute unit for one cycle, RESP holds the
// captured result until the owning requester takes it.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [3:0]  rq0_op,
  input  logic [15:0] rq0_a,
  input  logic [15:0] rq0_b,

  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [3:0]  rq1_op,
  input  logic [15:0] rq1_a,
  input  logic [15:0] rq1_b,

  output logic        rs0_valid,
  input  logic        rs0_ready,
  output logic        rs1_valid,
  input  logic        rs1_ready,
  output logic [15:0] rs_result,
  output logic        rs_zero,
  output logic        rs_err,

  output logic [15:0] alu_data1,
  output logic [15:0] alu_data2,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zero
);

  localparam logic FIXED = (FIXED_PRIO != 0);
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;             // 0 = requester 0, 1 = requester 1
  logic        last_served_q, last_served_d; // resets to 1 so requester 0 wins the first tie
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_data1_q, alu_data1_d;
  logic [15:0] alu_data2_q, alu_data2_d;
  logic [15:0] rs_result_q, rs_result_d;
  logic        rs_zero_q, rs_zero_d;
  logic        rs_err_q, rs_err_d;

  logic grant0;
  logic grant1;
  logic idle_open;
  logic owner_rs_ready;

  // Grant decision: depends only on valids, state and last_served, never on payload.
  always_comb begin
    grant0    = rq0_valid && (!rq1_valid || FIXED || last_served_q);
    grant1    = rq1_valid && !grant0;
    idle_open = (state_q == ST_IDLE) && !rst;
    rq0_ready = idle_open && grant0;
    rq1_ready = idle_open && grant1;
  end

  // Only the owner's response handshake can retire the operation.
  always_comb begin
    owner_rs_ready = owner_q ? rs1_ready : rs0_ready;
  end

  // Next-state computation for the FSM, the ALU operand registers and the response registers.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    alu_op_d      = alu_op_q;
    alu_data1_d   = alu_data1_q;
    alu_data2_d   = alu_data2_q;
    rs_result_d   = rs_result_q;
    rs_zero_d     = rs_zero_q;
    rs_err_d      = rs_err_q;
    case (state_q)
      ST_IDLE: begin
        if (rq0_ready) begin
          alu_op_d      = rq0_op;
          alu_data1_d   = rq0_a;
          alu_data2_d   = rq0_b;
          owner_d       = 1'b0;
          last_served_d = 1'b0;
          state_d       = ST_EXEC;
        end else if (rq1_ready) begin
          alu_op_d      = rq1_op;
          alu_data1_d   = rq1_a;
          alu_data2_d   = rq1_b;
          owner_d       = 1'b1;
          last_served_d = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The execute unit has had a full cycle to settle on the captured operands.
        rs_result_d = alu_result;
        rs_zero_d   = alu_zero;
        rs_err_d    = (alu_op_q == OP_ILLEGAL);
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // No accept here even if a request is waiting: IDLE must be visited first.
        if (owner_rs_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      alu_op_q      <= 4'd0;
      alu_data1_q   <= 16'd0;
      alu_data2_q   <= 16'd0;
      rs_result_q   <= 16'd0;
      rs_zero_q     <= 1'b0;
      rs_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      alu_op_q      <= alu_op_d;
      alu_data1_q   <= alu_data1_d;
      alu_data2_q   <= alu_data2_d;
      rs_result_q   <= rs_result_d;
      rs_zero_q     <= rs_zero_d;
      rs_err_q      <= rs_err_d;
    end
  end

  // Output mapping: everything comes straight from flops.
  always_comb begin
    rs0_valid = (state_q == ST_RESP) && !owner_q;
    rs1_valid = (state_q == ST_RESP) && owner_q;
    rs_result = rs_result_q;
    rs_zero   = rs_zero_q;
    rs_err    = rs_err_q;
    alu_op    = alu_op_q;
    alu_data1 = alu_data1_q;
    alu_data2 = alu_data2_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. Two instances share stimulus:
// dut (round-robin) and dut_fp (fixed priority). Each has its own ALU model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        rq0_valid, rq1_valid;
  logic [3:0]  rq0_op, rq1_op;
  logic [15:0] rq0_a, rq0_b, rq1_a, rq1_b;
  logic        rs0_ready, rs1_ready;

  logic        rq0_ready, rq1_ready, rs0_valid, rs1_valid;
  logic [15:0] rs_result, alu_data1, alu_data2, alu_result;
  logic        rs_zero, rs_err, alu_zero;
  logic [3:0]  alu_op;

  logic        fp_rq0_ready, fp_rq1_ready, fp_rs0_valid, fp_rs1_valid;
  logic [15:0] fp_rs_result, fp_alu_data1, fp_alu_data2, fp_alu_result;
  logic        fp_rs_zero, fp_rs_err, fp_alu_zero;
  logic [3:0]  fp_alu_op;

  int total;
  int bad;

  // Reference execute unit: op 1 is b-a (data2 - data1); op 15 returns a marker pattern.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] d1,
                                         input logic [15:0] d2);
    case (op)
      4'd0:    return d1 + d2;
      4'd1:    return d2 - d1;
      4'd2:    return d1 ^ d2;
      4'd3:    return d1 & d2;
      4'd15:   return 16'hBEEF ^ d1;
      default: return d1 | d2;
    endcase
  endfunction

  assign alu_result    = alu_fn(alu_op, alu_data1, alu_data2);
  assign alu_zero      = (alu_result == 16'd0);
  assign fp_alu_result = alu_fn(fp_alu_op, fp_alu_data1, fp_alu_data2);
  assign fp_alu_zero   = (fp_alu_result == 16'd0);

  alu_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs1_valid(rs1_valid), .rs1_ready(rs1_ready),
    .rs_result(rs_result), .rs_zero(rs_zero), .rs_err(rs_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(fp_rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq1_valid(rq1_valid), .rq1_ready(fp_rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rs0_valid(fp_rs0_valid), .rs0_ready(rs0_ready), .rs1_valid(fp_rs1_valid), .rs1_ready(rs1_ready),
    .rs_result(fp_rs_result), .rs_zero(fp_rs_zero), .rs_err(fp_rs_err),
    .alu_data1(fp_alu_data1), .alu_data2(fp_alu_data2), .alu_op(fp_alu_op),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rq0_op = 4'd0; rq0_a = 16'd0; rq0_b = 16'd0;
    rq1_op = 4'd0; rq1_a = 16'd0; rq1_b = 16'd0;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    #1;
    total++; if (rq0_ready !== 1'b0) begin bad++; $display("FAIL reset_rq0_ready got=%b exp=0", rq0_ready); end
    total++; if (rq1_ready !== 1'b0) begin bad++; $display("FAIL reset_rq1_ready got=%b exp=0", rq1_ready); end
    total++; if (rs0_valid !== 1'b0) begin bad++; $display("FAIL reset_rs0_valid got=%b exp=0", rs0_valid); end
    total++; if (rs1_valid !== 1'b0) begin bad++; $display("FAIL reset_rs1_valid got=%b exp=0", rs1_valid); end
    total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL reset_alu_op got=%h exp=0", alu_op); end
    total++; if (alu_data1 !== 16'd0) begin bad++; $display("FAIL reset_alu_data1 got=%h exp=0", alu_data1); end
    total++; if (alu_data2 !== 16'd0) begin bad++; $display("FAIL reset_alu_data2 got=%h exp=0", alu_data2); end
    total++; if (rs_result !== 16'd0) begin bad++; $display("FAIL reset_rs_result got=%h exp=0", rs_result); end
    total++; if (rs_zero !== 1'b0) begin bad++; $display("FAIL reset_rs_zero got=%b exp=0", rs_zero); end
    total++; if (rs_err !== 1'b0) begin bad++; $display("FAIL reset_rs_err got=%b exp=0", rs_err); end
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    $display("txn reset released");
  endtask

  // Lone add from requester 0 right after reset release: ready cycle 0, alu_op cycle 1, response cycle 2.
  task automatic test_single();
    rq0_valid = 1'b1; rq0_op = 4'd0; rq0_a = 16'h0003; rq0_b = 16'h0004;
    rs0_ready = 1'b1; rs1_ready = 1'b0;
    #1;
    total++; if (rq0_ready !== 1'b1) begin bad++; $display("FAIL single_c0_rq0_ready got=%b exp=1", rq0_ready); end
    total++; if (rq1_ready !== 1'b0) begin bad++; $display("FAIL single_c0_rq1_ready got=%b exp=0", rq1_ready); end
    tick();
    // new payload on the bus must not disturb the captured operands
    rq0_op = 4'd2; rq0_a = 16'h0009; rq0_b = 16'h0001;
    #1;
    total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL single_c1_alu_op got=%h exp=0", alu_op); end
    total++; if (alu_data1 !== 16'h0003) begin bad++; $display("FAIL single_c1_alu_data1 got=%h exp=0003", alu_data1); end
    total++; if (alu_data2 !== 16'h0004) begin bad++; $display("FAIL single_c1_alu_data2 got=%h exp=0004", alu_data2); end
    total++; if (rq0_ready !== 1'b0) begin bad++; $display("FAIL single_c1_rq0_ready got=%b exp=0", rq0_ready); end
    total++; if (rs0_valid !== 1'b0) begin bad++; $display("FAIL single_c1_rs0_valid got=%b exp=0", rs0_valid); end
    tick();
    total++; if (rs0_valid !== 1'b1) begin bad++; $display("FAIL single_c2_rs0_valid got=%b exp=1", rs0_valid); end
    total++; if (rs1_valid !== 1'b0) begin bad++; $display("FAIL single_c2_rs1_valid got=%b exp=0", rs1_valid); end
    total++; if (rs_result !== 16'h0007) begin bad++; $display("FAIL single_c2_rs_result got=%h exp=0007", rs_result); end
    total++; if (rs_zero !== 1'b0) begin bad++; $display("FAIL single_c2_rs_zero got=%b exp=0", rs_zero); end
    total++; if (rq0_ready !== 1'b0) begin bad++; $display("FAIL single_c2_rq0_ready got=%b exp=0", rq0_ready); end
    tick();
    total++; if (rq0_ready !== 1'b1) begin bad++; $display("FAIL single_c3_rq0_ready got=%b exp=1", rq0_ready); end
    // withdraw before the edge: legal, no accept
    rq0_valid = 1'b0;
    tick();
    total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL single_withdraw_alu_op got=%h exp=0", alu_op); end
    $display("txn single rq0 add 3+4 result=%h", rs_result);
    clear_inputs();
  endtask

  // Illegal op then a legal xor: error flag set, then cleared.
  task automatic test_illegal();
    rq0_valid = 1'b1; rq0_op = 4'd15; rq0_a = 16'h1234; rq0_b = 16'h00FF; rs0_ready = 1'b1;
    #1;
    total++; if (rq0_ready !== 1'b1) begin bad++; $display("FAIL illegal_rq0_ready got=%b exp=1", rq0_ready); end
    tick();
    rq0_valid = 1'b0;
    tick();
    total++; if (rs0_valid !== 1'b1) begin bad++; $display("FAIL illegal_rs0_valid got=%b exp=1", rs0_valid); end
    total++; if (rs_err !== 1'b1) begin bad++; $display("FAIL illegal_rs_err got=%b exp=1", rs_err); end
    total++; if (rs_result !== 16'hACDB) begin bad++; $display("FAIL illegal_rs_result got=%h exp=acdb", rs_result); end
    total++; if (rs_zero !== 1'b0) begin bad++; $display("FAIL illegal_rs_zero got=%b exp=0", rs_zero); end
    total++; if (alu_op !== 4'd15) begin bad++; $display("FAIL illegal_alu_op got=%h exp=f", alu_op); end
    $display("txn rq0 op15 result=%h err=%b", rs_result, rs_err);
    tick();
    rq0_valid = 1'b1; rq0_op = 4'd2; rq0_a = 16'h00FF; rq0_b = 16'h0F0F;
    #1;
    tick();
    rq0_valid = 1'b0;
    tick();
    total++; if (rs0_valid !== 1'b1) begin bad++; $display("FAIL xor_rs0_valid got=%b exp=1", rs0_valid); end
    total++; if (rs_err !== 1'b0) begin bad++; $display("FAIL xor_rs_err got=%b exp=0", rs_err); end
    total++; if (rs_result !== 16'h0FF0) begin bad++; $display("FAIL xor_rs_result got=%h exp=0ff0", rs_result); end
    $display("txn rq0 xor result=%h err=%b", rs_result, rs_err);
    tick();
    clear_inputs();
  endtask

  // Reset asserted mid-EXEC: everything returns to reset values at once, no stray response.
  task automatic test_reset_exec();
    rq0_valid = 1'b1; rq0_op = 4'd2; rq0_a = 16'h0F0F; rq0_b = 16'h00FF;
    #1;
    tick();
    rq0_valid = 1'b0;
    #1;
    total++; if (alu_op !== 4'd2) begin bad++; $display("FAIL rexec_pre_alu_op got=%h exp=2", alu_op); end
    rst = 1'b1;
    #1;
    total++; if (alu_op !== 4'd0) begin bad++; $display("FAIL rexec_alu_op got=%h exp=0", alu_op); end
    total++; if (alu_data1 !== 16'd0) begin bad++; $display("FAIL rexec_alu_data1 got=%h exp=0", alu_data1); end
    total++; if (alu_data2 !== 16'd0) begin bad++; $display("FAIL rexec_alu_data2 got=%h exp=0", alu_data2); end
    total++; if (rs_result !== 16'd0) begin bad++; $display("FAIL rexec_rs_result got=%h exp=0", rs_result); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if ((rs0_valid !== 1'b0) || (rs1_valid !== 1'b0)) begin bad++; $display("FAIL rexec_no_resp cyc=%0d got=%b%b exp=00", i, rs0_valid, rs1_valid); end
      tick();
    end
    rq1_valid = 1'b1; rq1_op = 4'd0; rq1_a = 16'h8000; rq1_b = 16'h8000; rs1_ready = 1'b1;
    #1;
    total++; if (rq1_ready !== 1'b1) begin bad++; $display("FAIL rexec_rq1_ready got=%b exp=1", rq1_ready); end
    tick();
    rq1_valid = 1'b0;
    tick();
    total++; if (rs1_valid !== 1'b1) begin bad++; $display("FAIL rexec_rs1_valid got=%b exp=1", rs1_valid); end
    total++; if (rs_zero !== 1'b1) begin bad++; $display("FAIL rexec_rs_zero got=%b exp=1", rs_zero); end
    $display("txn rq1 add after reset result=%h zero=%b", rs_result, rs_zero);
    tick();
    clear_inputs();
  endtask

  // Owner stalls its response for 10 cycles; waiting requester 0 must not be granted.
  task automatic test_hold();
    do_reset();
    rq1_valid = 1'b1; rq1_op = 4'd1; rq1_a = 16'h0005; rq1_b = 16'h0005;
    rs1_ready = 1'b0; rs0_ready = 1'b1;
    #1;
    total++; if (rq1_ready !== 1'b1) begin bad++; $display("FAIL hold_rq1_ready got=%b exp=1", rq1_ready); end
    tick();
    rq1_valid = 1'b0;
    rq0_valid = 1'b1; rq0_op = 4'd0; rq0_a = 16'h0001; rq0_b = 16'h0001;
    #1;
    total++; if (rq0_ready !== 1'b0) begin bad++; $display("FAIL hold_exec_rq0_ready got=%b exp=0", rq0_ready); end
    tick();
    for (int i = 0; i < 10; i++) begin
      total++; if (rs1_valid !== 1'b1) begin bad++; $display("FAIL hold_rs1_valid cyc=%0d got=%b exp=1", i, rs1_valid); end
      total++; if (rs0_valid !== 1'b0) begin bad++; $display("FAIL hold_rs0_valid cyc=%0d got=%b exp=0", i, rs0_valid); end
      total++; if (rs_result !== 16'h0000) begin bad++; $display("FAIL hold_rs_result cyc=%0d got=%h exp=0000", i, rs_result); end
      total++; if (rs_zero !== 1'b1) begin bad++; $display("FAIL hold_rs_zero cyc=%0d got=%b exp=1", i, rs_zero); end
      total++; if (rq0_ready !== 1'b0) begin bad++; $display("FAIL hold_rq0_ready cyc=%0d got=%b exp=0", i, rq0_ready); end
      tick();
    end
    rs1_ready = 1'b1;
    #1;
    total++; if (rs1_valid !== 1'b1) begin bad++; $display("FAIL hold_release_rs1_valid got=%b exp=1", rs1_valid); end
    $display("txn rq1 sub held result=%h zero=%b", rs_result, rs_zero);
    tick();
    rs1_ready = 1'b0;
    #1;
    total++; if (rq0_ready !== 1'b1) begin bad++; $display("FAIL hold_after_rq0_ready got=%b exp=1", rq0_ready); end
    tick();
    rq0_valid = 1'b0;
    tick();
    total++; if (rs0_valid !== 1'b1) begin bad++; $display("FAIL hold_rq0_rs0_valid got=%b exp=1", rs0_valid); end
    total++; if (rs_result !== 16'h0002) begin bad++; $display("FAIL hold_rq0_rs_result got=%h exp=0002", rs_result); end
    $display("txn rq0 add after wait result=%h", rs_result);
    tick();
    clear_inputs();
  endtask

  // Both requesters valid every cycle on the round-robin instance.
  task automatic test_round_robin();
    logic exp_r0, exp_r1, exp_v0, exp_v1;
    int phase, opn;
    do_reset();
    rq0_valid = 1'b1; rq0_op = 4'd0; rq0_a = 16'h0001; rq0_b = 16'h0002;
    rq1_valid = 1'b1; rq1_op = 4'd2; rq1_a = 16'h00F0; rq1_b = 16'h0FF0;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      phase = k % 3;
      opn = k / 3;
      exp_r0 = (phase == 0) && (opn % 2 == 0);
      exp_r1 = (phase == 0) && (opn % 2 == 1);
      exp_v0 = (phase == 2) && (opn % 2 == 0);
      exp_v1 = (phase == 2) && (opn % 2 == 1);
      total++; if (rq0_ready !== exp_r0) begin bad++; $display("FAIL rr_rq0_ready cyc=%0d got=%b exp=%b", k, rq0_ready, exp_r0); end
      total++; if (rq1_ready !== exp_r1) begin bad++; $display("FAIL rr_rq1_ready cyc=%0d got=%b exp=%b", k, rq1_ready, exp_r1); end
      total++; if (rs0_valid !== exp_v0) begin bad++; $display("FAIL rr_rs0_valid cyc=%0d got=%b exp=%b", k, rs0_valid, exp_v0); end
      total++; if (rs1_valid !== exp_v1) begin bad++; $display("FAIL rr_rs1_valid cyc=%0d got=%b exp=%b", k, rs1_valid, exp_v1); end
      if (phase == 2) begin
        total++;
        if (rs_result !== ((opn % 2 == 0) ? 16'h0003 : 16'h0F00)) begin
          bad++; $display("FAIL rr_rs_result cyc=%0d got=%h exp=%h", k, rs_result, (opn % 2 == 0) ? 16'h0003 : 16'h0F00);
        end
        $display("txn rr op%0d owner=%0d result=%h", opn, opn % 2, rs_result);
      end
      tick();
    end
    clear_inputs();
  endtask

  // Same stimulus on the fixed-priority instance: requester 0 always wins.
  task automatic test_fixed_prio();
    logic exp_r0, exp_v0;
    int phase;
    do_reset();
    rq0_valid = 1'b1; rq0_op = 4'd0; rq0_a = 16'h0001; rq0_b = 16'h0002;
    rq1_valid = 1'b1; rq1_op = 4'd2; rq1_a = 16'h00F0; rq1_b = 16'h0FF0;
    rs0_ready = 1'b1; rs1_ready = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      phase = k % 3;
      exp_r0 = (phase == 0);
      exp_v0 = (phase == 2);
      total++; if (fp_rq0_ready !== exp_r0) begin bad++; $display("FAIL fp_rq0_ready cyc=%0d got=%b exp=%b", k, fp_rq0_ready, exp_r0); end
      total++; if (fp_rq1_ready !== 1'b0) begin bad++; $display("FAIL fp_rq1_ready cyc=%0d got=%b exp=0", k, fp_rq1_ready); end
      total++; if (fp_rs0_valid !== exp_v0) begin bad++; $display("FAIL fp_rs0_valid cyc=%0d got=%b exp=%b", k, fp_rs0_valid, exp_v0); end
      total++; if (fp_rs1_valid !== 1'b0) begin bad++; $display("FAIL fp_rs1_valid cyc=%0d got=%b exp=0", k, fp_rs1_valid); end
      if (phase == 2) begin
        total++; if (fp_rs_result !== 16'h0003) begin bad++; $display("FAIL fp_rs_result cyc=%0d got=%h exp=0003", k, fp_rs_result); end
        $display("txn fp op%0d owner=0 result=%h", k / 3, fp_rs_result);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_illegal();
    test_reset_exec();
    test_hold();
    test_round_robin();
    test_fixed_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin grant; 1 = requester 0 always wins ties.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rq0_valid / rq1_valid  input  1 each  request pending from requester 0 / 1.
REQ-005 rq0_ready / rq1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-006 rq0_op / rq1_op  input  4 each  ALU opcode (0 add, 1 sub b-a, 2 xor, 3 and, 4-7 set, 8-11 shift, 12 andn, 13 slb, 14 btr, 15 illegal).
REQ-007 rq0_a, rq0_b / rq1_a, rq1_b  input  16 each  operands (a -> data1, b -> data2).
REQ-008 rs0_valid / rs1_valid  output  1 each  response valid to requester 0 / 1.
REQ-009 rs0_ready / rs1_ready  input  1 each  requester accepts response.
REQ-010 rs_result  output  16  shared captured ALU result.
REQ-011 rs_zero  output  1  captured ALU zero flag.
REQ-012 rs_err  output  1  captured op was 15.
REQ-013 alu_data1, alu_data2  output  16 each  to shared execute unit.
REQ-014 alu_op  output  4  to shared execute unit.
REQ-015 alu_result  input  16; alu_zero  input  1  combinational results from execute unit.

Function
REQ-016 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-017 IDLE: rqN_ready = 1 only for granted requester; at most one ready high per cycle; no ready in EXEC/RESP.
REQ-018 Grant, one requester valid: that requester.
REQ-019 Grant, both valid, FIXED_PRIO=0: requester not served last; last_served resets to 1 so requester 0 wins first tie.
REQ-020 Grant, both valid, FIXED_PRIO=1: requester 0.
REQ-021 rqN_ready is combinational from valids, state, last_served; it never depends on rqN_op/a/b.
REQ-022 Accept edge (IDLE, valid&ready): capture op, a, b into alu_op/alu_data1/alu_data2 registers, record owner, update last_served, go EXEC.
REQ-023 alu_* outputs are registers; they hold last captured values until next accept.
REQ-024 EXEC lasts exactly one cycle; at its closing edge capture alu_result -> rs_result, alu_zero -> rs_zero, (op==15) -> rs_err; go RESP.
REQ-025 RESP: rsN_valid = 1 for owner only; other rsN_valid = 0; rs_result/rs_zero/rs_err stable.
REQ-026 RESP and owner rsN_ready=1: go IDLE next edge; no accept in the same cycle (min 3 cycles per op, accept-to-rs_valid latency 2 cycles).
REQ-027 RESP held indefinitely while owner rsN_ready=0; new requests wait, no drop.
REQ-028 Non-owner rsN_ready ignored in all states.
REQ-029 Requester deasserting valid before accept is legal; no grant recorded, last_served unchanged.
REQ-030 Op 15: ALU still driven; result passed through unmodified, rs_err=1.

Reset
REQ-031 rst high, any state incl. mid-EXEC/RESP: immediately go IDLE, abort in-flight op, no response issued.
REQ-032 Reset values: alu_data1=0, alu_data2=0, alu_op=0, rs_result=0, rs_zero=0, rs_err=0, rs0/1_valid=0, rq0/1_ready=0 while rst high, last_served=1.
REQ-033 First edge after rst release: requests may be accepted.

Verification
REQ-034 rq0 op=0 a=0x0003 b=0x0004 alone -> rq0_ready cycle 0, alu_op=0 cycle 1, rs0_valid cycle 2 with rs_result=0x0007, rs_zero=0, rs1_valid=0.
REQ-035 rq0 and rq1 valid every cycle, rs ready=1, FIXED_PRIO=0 -> grants alternate 0,1,0,1; one accept per 3 cycles.
REQ-036 Same stimulus, FIXED_PRIO=1 -> requester 0 granted every time; rq1 never ready.
REQ-037 rq1 op=1 a=0x0005 b=0x0005, rs1_ready=0 for 10 cycles -> rs1_valid held, rs_result=0x0000, rs_zero=1; rq0 not ready until rs1 accepted.
REQ-038 rq0 op=15 -> rs_err=1, rs_result=alu_result; following op=2 -> rs_err=0.
REQ-039 rst asserted during EXEC -> outputs at reset values within same cycle; no rs_valid after release until new accept.
